// File: rtl/serial_read_master_if.sv
// Bus bundle between host-side control logic and the serial read master.
// The master modport faces the RTL; the slave modport faces host logic and the slave link.
`timescale 1ns/1ps
interface serial_read_master_if #(
    parameter int AW = 8,
    parameter int DW = 8
);
    logic          START;
    logic [AW-1:0] ADDR;
    logic          RX;
    logic          TX;
    logic          SCLK;
    logic          BUSY;
    logic          DONE;
    logic          NACK;
    logic [DW-1:0] DATA;

    modport master (
        input  START, ADDR, RX,
        output TX, SCLK, BUSY, DONE, NACK, DATA
    );

    modport slave (
        output START, ADDR, RX,
        input  TX, SCLK, BUSY, DONE, NACK, DATA
    );
endinterface

// File: rtl/serial_read_master.sv
// Serial read master: SOF, address MSB-first, ACK slot, data MSB-first, EOF.
// SCLK is divided from CLK internally; one word is read per accepted START.
`timescale 1ns/1ps
module serial_read_master #(
    parameter int AW     = 8,
    parameter int DW     = 8,
    parameter int CLKDIV = 4
) (
    input  logic                 CLK,
    input  logic                 RST,
    serial_read_master_if.master bus
);
    localparam int PW = $clog2(2 * CLKDIV);
    localparam int CW = $clog2(((AW > DW) ? AW : DW) + 1);
    localparam logic [PW-1:0] PH_LAST = PW'(2 * CLKDIV - 1);
    localparam logic [PW-1:0] PH_HIGH = PW'(CLKDIV);

    typedef enum logic [2:0] {S_IDLE, S_SOF, S_ADR, S_ACK, S_DAT, S_EOF} state_e;

    state_e        state_q, state_d;
    logic [PW-1:0] ph_q, ph_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] shift_q, shift_d;
    logic [DW-1:0] data_q, data_d;
    logic          nack_q, nack_d;
    logic          done_q, done_d;
    logic          ph_last;

    assign ph_last = (ph_q == PH_LAST);

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_d = state_q;
        ph_d    = '0;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        shift_d = shift_q;
        data_d  = data_q;
        nack_d  = nack_q;
        done_d  = 1'b0;

        if (state_q != S_IDLE) begin
            ph_d = ph_last ? '0 : ph_q + PW'(1);
        end

        unique case (state_q)
            S_IDLE: begin
                if (bus.START) begin
                    state_d = S_SOF;
                    addr_d  = bus.ADDR;
                    nack_d  = 1'b0;
                    cnt_d   = '0;
                end
            end
            S_SOF: begin
                if (ph_last) state_d = S_ADR;
            end
            S_ADR: begin
                // Address is shifted out of its own register so TX is always its MSB.
                if (ph_last) begin
                    addr_d = addr_q << 1;
                    if (cnt_q == CW'(AW - 1)) begin
                        cnt_d   = '0;
                        state_d = S_ACK;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            S_ACK: begin
                if (ph_last) begin
                    if (bus.RX) begin
                        state_d = S_DAT;
                    end else begin
                        nack_d  = 1'b1;
                        state_d = S_EOF;
                    end
                end
            end
            S_DAT: begin
                if (ph_last) begin
                    shift_d = (shift_q << 1) | DW'(bus.RX);
                    if (cnt_q == CW'(DW - 1)) begin
                        data_d  = shift_d;
                        cnt_d   = '0;
                        state_d = S_EOF;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            S_EOF: begin
                if (ph_last) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        // NOTE: every register, including the held DATA word, is reset so a mid-frame reset leaves no stale state.
        if (RST) begin
            state_q <= S_IDLE;
            ph_q    <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
            shift_q <= '0;
            data_q  <= '0;
            nack_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q <= state_d;
            ph_q    <= ph_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            nack_q  <= nack_d;
            done_q  <= done_d;
        end
    end

    // State and bit position only move at a phase wrap, so TX changes only at ph = 0.
    assign bus.TX   = (state_q == S_SOF) || ((state_q == S_ADR) && addr_q[AW-1]);
    assign bus.SCLK = (state_q != S_IDLE) && (ph_q >= PH_HIGH);
    assign bus.BUSY = (state_q != S_IDLE);
    assign bus.DONE = done_q;
    assign bus.NACK = nack_q;
    assign bus.DATA = data_q;
endmodule

// File: tb/tb_serial_read_master.sv
// Directed bench for serial_read_master: default instance with four model slaves,
// plus an AW=10/DW=16/CLKDIV=2 instance with a single slave.
`timescale 1ns/1ps
module tb_serial_read_master;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    serial_read_master_if #(.AW(8),  .DW(8))  bus  ();
    serial_read_master_if #(.AW(10), .DW(16)) bus2 ();

    serial_read_master #(.AW(8),  .DW(8),  .CLKDIV(4)) dut  (.CLK(clk), .RST(rst), .bus(bus));
    serial_read_master #(.AW(10), .DW(16), .CLKDIV(2)) dut2 (.CLK(clk), .RST(rst), .bus(bus2));

    int n_checks = 0;
    int n_fail   = 0;

    // Slave population for the default instance: decodes TX on SCLK rise, drives RX on SCLK fall.
    function automatic logic [8:0] slave_lookup(input logic [7:0] a);
        case (a)
            8'h1A:   return {1'b1, 8'h5D};
            8'h1B:   return {1'b1, 8'h3F};
            8'h2A:   return {1'b1, 8'h41};
            8'h2B:   return {1'b1, 8'h6C};
            default: return 9'h000;
        endcase
    endfunction

    int         m_n;
    logic [7:0] m_addr;
    logic       m_hit;
    logic [7:0] m_data;
    logic       m_sclk_prev;
    always @(negedge clk) begin
        if (bus.BUSY !== 1'b1) begin
            m_n = 0; m_hit = 1'b0; bus.RX = 1'b0;
        end else if (bus.SCLK && !m_sclk_prev) begin
            if (m_n >= 1 && m_n <= 8) m_addr = {m_addr[6:0], bus.TX};
            m_n++;
        end else if (!bus.SCLK && m_sclk_prev) begin
            if (m_n == 9) begin
                {m_hit, m_data} = slave_lookup(m_addr);
                bus.RX = m_hit;
            end else if (m_hit && m_n >= 10 && m_n <= 17) begin
                bus.RX = m_data[17 - m_n];
            end else begin
                bus.RX = 1'b0;
            end
        end
        m_sclk_prev = bus.SCLK;
    end

    // Single slave at 0x2C5 returning 0xBEEF for the wide instance.
    int          m2_n;
    logic [9:0]  m2_addr;
    logic        m2_hit;
    logic [15:0] m2_data;
    logic        m2_sclk_prev;
    always @(negedge clk) begin
        if (bus2.BUSY !== 1'b1) begin
            m2_n = 0; m2_hit = 1'b0; bus2.RX = 1'b0;
        end else if (bus2.SCLK && !m2_sclk_prev) begin
            if (m2_n >= 1 && m2_n <= 10) m2_addr = {m2_addr[8:0], bus2.TX};
            m2_n++;
        end else if (!bus2.SCLK && m2_sclk_prev) begin
            if (m2_n == 11) begin
                m2_hit  = (m2_addr == 10'h2C5);
                m2_data = 16'hBEEF;
                bus2.RX = m2_hit;
            end else if (m2_hit && m2_n >= 12 && m2_n <= 27) begin
                bus2.RX = m2_data[27 - m2_n];
            end else begin
                bus2.RX = 1'b0;
            end
        end
        m2_sclk_prev = bus2.SCLK;
    end

    task automatic start_frame(input logic [7:0] addr);
        @(negedge clk);
        bus.START = 1'b1;
        bus.ADDR  = addr;
        @(posedge clk); #1;
        bus.START = 1'b0;
    endtask

    // Runs until BUSY drops (or a cycle budget expires); returns at the negedge of the DONE cycle.
    task automatic wait_frame(input int pulse_at, input logic [7:0] pulse_addr,
                              output int busy_cycles, output int dones, output logic [9:0] tx_bits);
        busy_cycles = 0; dones = 0; tx_bits = '0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (bus.BUSY !== 1'b1) break;
            if (busy_cycles < 80 && busy_cycles % 8 == 0) tx_bits = {tx_bits[8:0], bus.TX};
            if (bus.DONE === 1'b1) dones++;
            if (busy_cycles == pulse_at) begin
                bus.START = 1'b1;
                bus.ADDR  = pulse_addr;
            end else if (busy_cycles == pulse_at + 1) begin
                bus.START = 1'b0;
            end
            busy_cycles++;
        end
        if (bus.DONE === 1'b1) dones++;
    endtask

    task automatic test_power_on;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++; if (bus.BUSY !== 1'b0) begin n_fail++; $display("FAIL por_busy got=%b exp=0", bus.BUSY); end
        n_checks++; if (bus.SCLK !== 1'b0) begin n_fail++; $display("FAIL por_sclk got=%b exp=0", bus.SCLK); end
        n_checks++; if (bus.DATA !== 8'h00) begin n_fail++; $display("FAIL por_data got=%h exp=00", bus.DATA); end
        n_checks++; if (bus2.BUSY !== 1'b0) begin n_fail++; $display("FAIL por_busy2 got=%b exp=0", bus2.BUSY); end
        rst = 1'b0;
    endtask

    task automatic test_single_read;
        int bc, dn; logic [9:0] txb;
        start_frame(8'h1A);
        wait_frame(-1, 8'h00, bc, dn, txb);
        n_checks++; if (bc != 152) begin n_fail++; $display("FAIL single_busy_len got=%0d exp=152", bc); end
        n_checks++; if (txb !== 10'b1000110100) begin n_fail++; $display("FAIL single_tx_bits got=%b exp=1000110100", txb); end
        n_checks++; if (dn != 1) begin n_fail++; $display("FAIL single_done_count got=%0d exp=1", dn); end
        n_checks++; if (bus.DATA !== 8'h5D) begin n_fail++; $display("FAIL single_data got=%h exp=5d", bus.DATA); end
        n_checks++; if (bus.NACK !== 1'b0) begin n_fail++; $display("FAIL single_nack got=%b exp=0", bus.NACK); end
        @(negedge clk);
        n_checks++; if (bus.DONE !== 1'b0) begin n_fail++; $display("FAIL single_done_width got=%b exp=0", bus.DONE); end
    endtask

    task automatic test_back_to_back;
        logic [7:0] addrs [3] = '{8'h1B, 8'h2A, 8'h2B};
        logic [7:0] exps  [3] = '{8'h3F, 8'h41, 8'h6C};
        int bc, dn; logic [9:0] txb;
        start_frame(addrs[0]);
        for (int k = 0; k < 3; k++) begin
            wait_frame(-1, 8'h00, bc, dn, txb);
            n_checks++; if (bc != 152) begin n_fail++; $display("FAIL b2b_busy_len[%0d] got=%0d exp=152", k, bc); end
            n_checks++; if (bus.DATA !== exps[k]) begin n_fail++; $display("FAIL b2b_data[%0d] got=%h exp=%h", k, bus.DATA, exps[k]); end
            n_checks++; if (dn != 1) begin n_fail++; $display("FAIL b2b_done[%0d] got=%0d exp=1", k, dn); end
            if (k < 2) begin
                bus.START = 1'b1;
                bus.ADDR  = addrs[k+1];
                @(posedge clk); #1;
                bus.START = 1'b0;
                n_checks++; if (bus.BUSY !== 1'b1) begin n_fail++; $display("FAIL b2b_no_gap[%0d] got=%b exp=1", k, bus.BUSY); end
            end
        end
    endtask

    task automatic test_nack;
        int bc, dn; logic [9:0] txb;
        start_frame(8'h55);
        wait_frame(-1, 8'h00, bc, dn, txb);
        n_checks++; if (bc != 88) begin n_fail++; $display("FAIL nack_busy_len got=%0d exp=88", bc); end
        n_checks++; if (dn != 1) begin n_fail++; $display("FAIL nack_done got=%0d exp=1", dn); end
        n_checks++; if (bus.NACK !== 1'b1) begin n_fail++; $display("FAIL nack_flag got=%b exp=1", bus.NACK); end
        n_checks++; if (bus.DATA !== 8'h6C) begin n_fail++; $display("FAIL nack_data_held got=%h exp=6c", bus.DATA); end
        start_frame(8'h1A);
        n_checks++; if (bus.NACK !== 1'b0) begin n_fail++; $display("FAIL nack_clear got=%b exp=0", bus.NACK); end
        wait_frame(-1, 8'h00, bc, dn, txb);
        n_checks++; if (bus.DATA !== 8'h5D) begin n_fail++; $display("FAIL nack_next_data got=%h exp=5d", bus.DATA); end
    endtask

    task automatic test_ignored_start;
        int bc, dn, extra; logic [9:0] txb;
        start_frame(8'h1B);
        wait_frame(40, 8'h2A, bc, dn, txb);
        n_checks++; if (bc != 152) begin n_fail++; $display("FAIL ign_busy_len got=%0d exp=152", bc); end
        n_checks++; if (bus.DATA !== 8'h3F) begin n_fail++; $display("FAIL ign_data got=%h exp=3f", bus.DATA); end
        n_checks++; if (dn != 1) begin n_fail++; $display("FAIL ign_done got=%0d exp=1", dn); end
        extra = 0;
        repeat (200) begin
            @(negedge clk);
            if (bus.BUSY !== 1'b0 || bus.DONE !== 1'b0) extra++;
        end
        n_checks++; if (extra != 0) begin n_fail++; $display("FAIL ign_not_queued got=%0d exp=0", extra); end
    endtask

    task automatic test_reset;
        int activity;
        start_frame(8'h1A);
        repeat (50) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_checks++; if (bus.SCLK !== 1'b0) begin n_fail++; $display("FAIL rst_sclk got=%b exp=0", bus.SCLK); end
        n_checks++; if (bus.TX !== 1'b0) begin n_fail++; $display("FAIL rst_tx got=%b exp=0", bus.TX); end
        n_checks++; if (bus.BUSY !== 1'b0) begin n_fail++; $display("FAIL rst_busy got=%b exp=0", bus.BUSY); end
        n_checks++; if (bus.DONE !== 1'b0) begin n_fail++; $display("FAIL rst_done got=%b exp=0", bus.DONE); end
        n_checks++; if (bus.NACK !== 1'b0) begin n_fail++; $display("FAIL rst_nack got=%b exp=0", bus.NACK); end
        n_checks++; if (bus.DATA !== 8'h00) begin n_fail++; $display("FAIL rst_data got=%h exp=00", bus.DATA); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        activity = 0;
        repeat (200) begin
            @(negedge clk);
            if (bus.DONE !== 1'b0 || bus.BUSY !== 1'b0) activity++;
        end
        n_checks++; if (activity != 0) begin n_fail++; $display("FAIL rst_no_done got=%0d exp=0", activity); end
    endtask

    task automatic test_param;
        int bc, dn, rise1, rise2;
        logic prev;
        bc = 0; dn = 0; rise1 = -1; rise2 = -1; prev = 1'b0;
        @(negedge clk);
        bus2.START = 1'b1;
        bus2.ADDR  = 10'h2C5;
        @(posedge clk); #1;
        bus2.START = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (bus2.BUSY !== 1'b1) break;
            if (bus2.SCLK === 1'b1 && !prev) begin
                if (rise1 < 0) rise1 = bc;
                else if (rise2 < 0) rise2 = bc;
            end
            prev = bus2.SCLK;
            if (bus2.DONE === 1'b1) dn++;
            bc++;
        end
        if (bus2.DONE === 1'b1) dn++;
        n_checks++; if (bc != 116) begin n_fail++; $display("FAIL param_busy_len got=%0d exp=116", bc); end
        n_checks++; if (bus2.DATA !== 16'hBEEF) begin n_fail++; $display("FAIL param_data got=%h exp=beef", bus2.DATA); end
        n_checks++; if (bus2.NACK !== 1'b0) begin n_fail++; $display("FAIL param_nack got=%b exp=0", bus2.NACK); end
        n_checks++; if (dn != 1) begin n_fail++; $display("FAIL param_done got=%0d exp=1", dn); end
        n_checks++; if (rise2 - rise1 != 4) begin n_fail++; $display("FAIL param_sclk_period got=%0d exp=4", rise2 - rise1); end
    endtask

    initial begin
        bus.START  = 1'b0;
        bus.ADDR   = 8'h00;
        bus2.START = 1'b0;
        bus2.ADDR  = 10'h000;
        test_power_on();
        test_single_read();
        test_back_to_back();
        test_nack();
        test_ignored_start();
        test_reset();
        test_param();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
